config_frame_writer: RTL and testbench

- Producer side of the per-row frame data registers.
- Accepts a stream of 32-bit configuration words over a valid/ready handshake.
- Parses one header word per frame, then broadcasts NumberOfRows data words on FrameData_O, stepping RowSelect_O through rows 1..NumberOfRows.
- After the last row has been captured, pulses one bit of FrameStrobe_O so the selected frame latches the row registers.

---
 rtl/config_frame_writer_if.sv | 12 +
 rtl/config_frame_writer.sv | 129 ++++++++++++
 tb/tb_config_frame_writer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/config_frame_writer_if.sv
// Write-side handshake between a configuration word source and config_frame_writer.
// The source drives WriteData/WriteValid, and the writer answers with WriteReady.
interface config_frame_writer_if #(
    parameter int FrameBitsPerRow = 32
) ();
    logic [FrameBitsPerRow-1:0] WriteData;
    logic                       WriteValid;
    logic                       WriteReady;

    modport master (output WriteData, output WriteValid, input WriteReady);
    modport slave  (input WriteData, input WriteValid, output WriteReady);
endinterface

// File: rtl/config_frame_writer.sv
// Parses one header word and then a fixed number of row words per frame.
// It broadcasts the rows to the row registers and pulses a one-hot frame latch strobe.
//
// state  | meaning
// IDLE   | waiting for a header word; bad headers set the sticky error
// ROWS   | accepting data words for rows 1..NumberOfRows
// SETTLE | last row is being captured; input stalled
// STROBE | one-hot frame latch pulse; input stalled
module config_frame_writer #(
    parameter int FrameBitsPerRow = 32,
    parameter int RowSelectWidth  = 5,
    parameter int NumberOfRows    = 16,
    parameter int FramesPerCol    = 20,
    parameter int FrameIdxWidth   = 5
) (
    input  logic                       CLK,
    input  logic                       RESET,
    config_frame_writer_if.slave       wr,
    output logic [FrameBitsPerRow-1:0] FrameData_O,
    output logic [RowSelectWidth-1:0]  RowSelect_O,
    output logic [FramesPerCol-1:0]    FrameStrobe_O,
    output logic                       Busy_O,
    output logic                       Error_O,
    output logic [15:0]                FrameCount_O
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ROWS   = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [1:0] STROBE = 2'd3;

    localparam logic [RowSelectWidth-1:0] LAST_ROW = RowSelectWidth'(NumberOfRows);

    if (NumberOfRows >= 2**RowSelectWidth) begin : g_row_width_check
        $error("NumberOfRows does not fit in RowSelectWidth");
    end

    logic [1:0]                 state_q, state_d;
    logic [RowSelectWidth-1:0]  row_q, row_d;
    logic [FrameIdxWidth-1:0]   idx_q, idx_d;
    logic [FrameBitsPerRow-1:0] data_q, data_d;
    logic [RowSelectWidth-1:0]  sel_q, sel_d;
    logic [FramesPerCol-1:0]    strobe_q, strobe_d;
    logic                       err_q, err_d;
    logic [15:0]                count_q, count_d;

    logic                     accept;
    logic                     hdr_ok;
    logic [FrameIdxWidth-1:0] hdr_idx;

    assign wr.WriteReady = (state_q == IDLE) || (state_q == ROWS);
    assign accept        = wr.WriteValid && wr.WriteReady;
    assign hdr_idx       = wr.WriteData[FrameIdxWidth-1:0];
    assign hdr_ok        = (wr.WriteData[31:24] == 8'hFA) && (32'(hdr_idx) < FramesPerCol);

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        idx_d    = idx_q;
        data_d   = data_q;
        sel_d    = '0;
        strobe_d = '0;
        err_d    = err_q;
        count_d  = count_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (hdr_ok) begin
                        idx_d   = hdr_idx;
                        row_d   = RowSelectWidth'(1);
                        state_d = ROWS;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ROWS: begin
                // Row select is registered with the word, so the row captures one edge later.
                if (accept) begin
                    data_d = wr.WriteData;
                    sel_d  = row_q;
                    if (row_q == LAST_ROW) begin
                        row_d   = '0;
                        state_d = SETTLE;
                    end else begin
                        row_d = row_q + RowSelectWidth'(1);
                    end
                end
            end
            SETTLE: begin
                strobe_d = FramesPerCol'(1) << idx_q;
                state_d  = STROBE;
            end
            STROBE: begin
                count_d = count_q + 16'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            row_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            sel_q    <= '0;
            strobe_q <= '0;
            err_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            sel_q    <= sel_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
            count_q  <= count_d;
        end
    end

    assign FrameData_O   = data_q;
    assign RowSelect_O   = sel_q;
    assign FrameStrobe_O = strobe_q;
    assign Busy_O        = (state_q != IDLE);
    assign Error_O       = err_q;
    assign FrameCount_O  = count_q;
endmodule

// File: tb/tb_config_frame_writer.sv
// Bench for config_frame_writer: frame-level model feeds expected row writes and strobes
// into queues, and a negedge monitor pops and compares them as the DUT presents them.
module tb_config_frame_writer;
    localparam int NROWS = 16;

    typedef struct packed {
        logic [4:0]  row;
        logic [31:0] data;
    } row_t;
    typedef struct packed {
        logic [19:0] strb;
        logic [15:0] cnt;
    } strb_t;

    logic        clk = 1'b0;
    logic        RESET;
    logic [31:0] FrameData_O;
    logic [4:0]  RowSelect_O;
    logic [19:0] FrameStrobe_O;
    logic        Busy_O;
    logic        Error_O;
    logic [15:0] FrameCount_O;

    config_frame_writer_if #(.FrameBitsPerRow(32)) wr_if ();

    config_frame_writer dut (
        .CLK          (clk),
        .RESET        (RESET),
        .wr           (wr_if.slave),
        .FrameData_O  (FrameData_O),
        .RowSelect_O  (RowSelect_O),
        .FrameStrobe_O(FrameStrobe_O),
        .Busy_O       (Busy_O),
        .Error_O      (Error_O),
        .FrameCount_O (FrameCount_O)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    row_t        row_exp[$];
    strb_t       strb_exp[$];
    logic [15:0] exp_count = '0;
    logic        exp_err   = 1'b0;
    logic [31:0] words[NROWS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every row select and strobe the DUT shows must be the next one the model expects.
    logic        cnt_pending = 1'b0;
    logic [15:0] cnt_exp;
    initial begin
        row_t  r;
        strb_t s;
        forever begin
            @(negedge clk);
            if (!RESET) begin
                check("strobe_onehot", 32'($countones(FrameStrobe_O) <= 1), 32'd1);
                check("row_strobe_overlap",
                      32'((RowSelect_O != 0) && (FrameStrobe_O != 0)), 32'd0);
                if (RowSelect_O != 0) begin
                    if (row_exp.size() == 0) begin
                        check("row_unexpected", 32'(RowSelect_O), 32'd0);
                    end else begin
                        r = row_exp.pop_front();
                        check("row_select", 32'(RowSelect_O), 32'(r.row));
                        check("row_data", FrameData_O, r.data);
                    end
                end
                if (cnt_pending) begin
                    check("frame_count", 32'(FrameCount_O), 32'(cnt_exp));
                    cnt_pending = 1'b0;
                end
                if (FrameStrobe_O != 0) begin
                    if (strb_exp.size() == 0) begin
                        check("strobe_unexpected", 32'(FrameStrobe_O), 32'd0);
                    end else begin
                        s = strb_exp.pop_front();
                        check("strobe_value", 32'(FrameStrobe_O), 32'(s.strb));
                        cnt_exp     = s.cnt;
                        cnt_pending = 1'b1;
                    end
                end
            end
        end
    end

    task automatic send_word(input logic [31:0] w);
        int budget = 64;
        wr_if.WriteData  = w;
        wr_if.WriteValid = 1'b1;
        while (!wr_if.WriteReady && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=WriteReady_low required=WriteReady_high");
            wr_if.WriteValid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        wr_if.WriteValid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run_frame(input int idx, input int gap_row, input int gap_len);
        logic [19:0] strb;
        strb = 20'(1) << idx;
        exp_count = exp_count + 16'd1;
        strb_exp.push_back('{strb: strb, cnt: exp_count});
        send_word(32'hFA000000 | 32'(idx));
        check("busy_after_header", 32'(Busy_O), 32'd1);
        for (int r = 1; r <= NROWS; r++) begin
            row_exp.push_back('{row: 5'(r), data: words[r-1]});
            send_word(words[r-1]);
            if (r == gap_row && gap_len > 0) begin
                idle_cycles(1);
                check("gap_row_zero", 32'(RowSelect_O), 32'd0);
                idle_cycles(gap_len - 1);
            end
        end
        check("settle_ready", 32'(wr_if.WriteReady), 32'd0);
        check("settle_row", 32'(RowSelect_O), 32'(NROWS));
        idle_cycles(1);
        check("strobe_ready", 32'(wr_if.WriteReady), 32'd0);
        check("strobe_latency", 32'(FrameStrobe_O), 32'(strb));
        idle_cycles(1);
        check("ready_return", 32'(wr_if.WriteReady), 32'd1);
        check("busy_return", 32'(Busy_O), 32'd0);
        check("count_after", 32'(FrameCount_O), 32'(exp_count));
    endtask

    task automatic bad_header(input logic [31:0] w);
        exp_err = 1'b1;
        send_word(w);
        check("bad_hdr_error", 32'(Error_O), 32'(exp_err));
        check("bad_hdr_busy", 32'(Busy_O), 32'd0);
        idle_cycles(1);
        check("bad_hdr_rowsel", 32'(RowSelect_O), 32'd0);
    endtask

    task automatic random_words();
        for (int i = 0; i < NROWS; i++) begin
            words[i] = $urandom;
            if ($urandom_range(3) == 0) words[i][31:24] = 8'hFA;
        end
    endtask

    initial begin
        logic [31:0] w;
        RESET            = 1'b1;
        wr_if.WriteValid = 1'b0;
        wr_if.WriteData  = '0;
        #22;
        check("rst_data", FrameData_O, 32'd0);
        check("rst_rowsel", 32'(RowSelect_O), 32'd0);
        check("rst_strobe", 32'(FrameStrobe_O), 32'd0);
        check("rst_busy", 32'(Busy_O), 32'd0);
        check("rst_error", 32'(Error_O), 32'd0);
        check("rst_count", 32'(FrameCount_O), 32'd0);
        RESET = 1'b0;
        idle_cycles(1);
        check("rst_ready", 32'(wr_if.WriteReady), 32'd1);

        for (int i = 0; i < NROWS; i++) words[i] = 32'h101 + 32'(i);
        run_frame(3, 0, 0);
        run_frame(3, 5, 3);

        bad_header(32'h12000003);
        bad_header(32'hFA000015);
        for (int i = 0; i < NROWS; i++) words[i] = 32'h200 + 32'(i);
        run_frame(19, 0, 0);
        check("error_sticky", 32'(Error_O), 32'(exp_err));

        random_words();
        words[1] = 32'hFA000001;
        run_frame(7, 0, 0);

        // Abandon a frame after row 7: everything clears without a clock edge.
        random_words();
        send_word(32'hFA000004);
        for (int r = 1; r <= 7; r++) begin
            row_exp.push_back('{row: 5'(r), data: words[r-1]});
            send_word(words[r-1]);
        end
        @(negedge clk); #1;
        RESET = 1'b1;
        #1;
        row_exp.delete();
        strb_exp.delete();
        exp_count = '0;
        exp_err   = 1'b0;
        check("midrst_rowsel", 32'(RowSelect_O), 32'd0);
        check("midrst_data", FrameData_O, 32'd0);
        check("midrst_busy", 32'(Busy_O), 32'd0);
        check("midrst_error", 32'(Error_O), 32'd0);
        check("midrst_count", 32'(FrameCount_O), 32'd0);
        @(posedge clk); #2;
        RESET = 1'b0;
        idle_cycles(3);
        check("postrst_strobe", 32'(FrameStrobe_O), 32'd0);
        random_words();
        run_frame(0, 0, 0);

        for (int f = 0; f < 20; f++) begin
            if ($urandom_range(3) == 0) begin
                w = $urandom;
                if ($urandom_range(1) == 0) w = 32'hFA000000 | 32'($urandom_range(31, 20));
                else if (w[31:24] == 8'hFA) w[31:24] = 8'h00;
                bad_header(w);
            end
            if ($urandom_range(1) == 0) idle_cycles($urandom_range(3));
            random_words();
            run_frame($urandom_range(19), $urandom_range(15, 1), $urandom_range(3));
        end

        idle_cycles(1);
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        exp_count = 16'hFFFF;
        check("preload_count", 32'(FrameCount_O), 32'hFFFF);
        random_words();
        run_frame(12, 0, 0);
        check("count_wrap", 32'(FrameCount_O), 32'd0);

        idle_cycles(2);
        check("rows_drained", 32'(row_exp.size()), 32'd0);
        check("strobes_drained", 32'(strb_exp.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
